memory_reg_stage_module: RTL and testbench
==========================================

// Module: memory_reg_stage_module
// PURPOSE
//   MEM stage of the 5-stage RISC-V pipeline. Holds the data memory, performs loads/stores for the
//   instruction in M, and registers the MEM/WB pipeline register feeding writeback_reg_stage_module.
//   Outputs map 1:1 onto the writeback stage inputs (RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W).
// PARAMETERS
//   DMEM_WORDS  64  data memory depth in 32-bit words; power of 2, >=4
// PORTS
//   clk          in   1   pipeline clock, rising edge
//   rst          in   1   reset, asynchronous, active-low
//   RegWriteM    in   1   register write enable of M instr
//   ResultSrcM   in   1   0=ALU result, 1=load data (WB mux select)
//   MemWriteM    in   1   store enable of M instr
//   funct3M      in   3   load/store size code (used only with MEM_SUBWORD_EN)
//   ALUResultM   in   32  effective address / ALU result
//   WriteDataM   in   32  store data (rs2, already forwarded)
//   RdM          in   5   destination register
//   PCPlus4M     in   32  PC+4 of M instr
//   RegWriteW    out  1   registered RegWriteM
//   ResultSrcW   out  1   registered ResultSrcM
//   ALUResultW   out  32  registered ALUResultM
//   ReadDataW    out  32  registered load data
//   RdW          out  5   registered RdM
//   PCPlus4W     out  32  registered PCPlus4M
//   MisalignW    out  1   registered misaligned-access flag (0 without MEM_SUBWORD_EN)
// BEHAVIOUR
//   - Reset: while rst=0 all W outputs = 0 asynchronously; stores suppressed. Memory contents not reset.
//   - Word index = ALUResultM[AW+1:2], AW=log2(DMEM_WORDS); higher address bits ignored (aliasing/wrap).
//   - Read: combinational from array, captured into ReadDataW at posedge -> data valid in WB one cycle after M.
//   - Write: at posedge when MemWriteM=1 and rst=1. Same-cycle read+write same word: ReadDataW gets OLD data.
//   - Back-to-back store then load same word: load (next cycle) sees new data.
//   - All M->W fields registered every posedge; no stall/flush inputs (bubbles arrive as zeroed controls).
//   - ReadDataW captured every cycle regardless of ResultSrcM; WB selects via ResultSrcW.
//   - Latency: exactly 1 cycle M->W for every output.
// CONFIGURATION
//   MEM_SUBWORD_EN defined:
//     - Loads by funct3M: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte/half selected by ALUResultM[1:0],
//       LB/LH sign-extend, LBU/LHU zero-extend. Other codes behave as LW.
//     - Stores: 000 SB, 001 SH, 010 SW; per-byte write enables from ALUResultM[1:0], WriteDataM low
//       byte/half replicated into the addressed lane; untouched bytes preserved.
//     - Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> store suppressed, load data 0,
//       MisalignW=1 for that instr (only when MemWriteM=1 or ResultSrcM=1).
//   MEM_SUBWORD_EN undefined: funct3M ignored; all accesses full-word, ALUResultM[1:0] ignored;
//   MisalignW tied 0.
// TESTING
//   T1 reset: rst=0 mid-run with MemWriteM=1 -> all W outputs 0 immediately, target word unchanged.
//   T2 SW 0xDEADBEEF @0x10, next cycle LW @0x10 (ResultSrcM=1) -> one cycle later ReadDataW=0xDEADBEEF, RdW matches.
//   T3 store+load same word same cycle (old 0x11111111, new 0x22222222) -> ReadDataW=0x11111111; next LW -> 0x22222222.
//   T4 wrap: DMEM_WORDS=64, SW @0x100 then LW @0x000 -> same data returned.
//   T5 [EN] word 0x80FF7F01 @0x20: LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80FF.
//   T6 [EN] SB 0xAB @0x21 -> word 0x80FFAB01; SH @0x21 -> MisalignW=1, word unchanged. [no EN] MisalignW always 0.

Source files
------------

// File: rtl/memory_reg_stage_module.sv
// MEM stage: data memory access plus the MEM/WB pipeline register.
// Define MEM_SUBWORD_EN to enable byte/half loads and stores with misalignment detection.
module memory_reg_stage_module #(
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignW
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0]   mem [DMEM_WORDS];
    logic [AW-1:0] wordIdx;
    logic [31:0]   rdWord;
    logic [31:0]   loadData;
    logic [31:0]   storeData;
    logic [3:0]    byteEn;
    logic          misalign;
    logic          unusedBits;

    // Upper address bits are dropped, so addresses alias modulo the memory size.
    assign wordIdx = ALUResultM[AW+1:2];
    assign rdWord  = mem[wordIdx];

`ifdef MEM_SUBWORD_EN
    logic [1:0]  offset;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    assign offset     = ALUResultM[1:0];
    assign loadByte   = rdWord[{offset, 3'b000} +: 8];
    assign loadHalf   = offset[1] ? rdWord[31:16] : rdWord[15:0];
    assign unusedBits = ^ALUResultM[31:AW+2];

    // funct3M[1:0] gives the access size; funct3M[2] selects zero-extension on loads.
    always_comb begin
        misalign  = 1'b0;
        byteEn    = 4'b1111;
        storeData = WriteDataM;
        loadData  = rdWord;
        case (funct3M[1:0])
            2'b00: begin
                byteEn    = 4'b0001 << offset;
                storeData = {4{WriteDataM[7:0]}};
                loadData  = {{24{loadByte[7] & ~funct3M[2]}}, loadByte};
            end
            2'b01: begin
                misalign  = offset[0];
                byteEn    = offset[1] ? 4'b1100 : 4'b0011;
                storeData = {2{WriteDataM[15:0]}};
                loadData  = {{16{loadHalf[15] & ~funct3M[2]}}, loadHalf};
            end
            default: misalign = (offset != 2'b00);
        endcase
        if (misalign) begin
            byteEn   = 4'b0000;
            loadData = 32'h0;
        end
    end
`else
    assign misalign   = 1'b0;
    assign byteEn     = 4'b1111;
    assign storeData  = WriteDataM;
    assign loadData   = rdWord;
    assign unusedBits = ^{ALUResultM[31:AW+2], ALUResultM[1:0], funct3M};
`endif

    // Memory is not reset; stores are only blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && MemWriteM) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            RdW        <= 5'h0;
            PCPlus4W   <= 32'h0;
            MisalignW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= loadData;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            MisalignW  <= misalign & (MemWriteM | ResultSrcM);
        end
    end
endmodule

// File: tb/tb_memory_reg_stage_module.sv
// Scoreboard bench for memory_reg_stage_module; expectations pushed at issue, checked by a monitor.
module tb_memory_reg_stage_module;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteM = 1'b0, ResultSrcM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  funct3M = 3'b010;
    logic [31:0] ALUResultM = '0, WriteDataM = '0, PCPlus4M = '0;
    logic [4:0]  RdM = '0;
    logic        RegWriteW, ResultSrcW, MisalignW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;

    memory_reg_stage_module #(.DMEM_WORDS(64)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W), .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        rw, rs, chkRd, mis;
        logic [31:0] alu, rdData, pc;
        logic [4:0]  rd;
    } expT;

    expT         q[$];
    int          checks = 0;
    int          errors = 0;
    int          opId   = 0;
    logic [31:0] pcCnt  = 32'h100;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL op%0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    task automatic chkResetOutputs(input int id);
        chk("rst RegWriteW",  id, {31'h0, RegWriteW},  32'h0);
        chk("rst ResultSrcW", id, {31'h0, ResultSrcW}, 32'h0);
        chk("rst ALUResultW", id, ALUResultW,          32'h0);
        chk("rst ReadDataW",  id, ReadDataW,           32'h0);
        chk("rst RdW",        id, {27'h0, RdW},        32'h0);
        chk("rst PCPlus4W",   id, PCPlus4W,            32'h0);
        chk("rst MisalignW",  id, {31'h0, MisalignW},  32'h0);
    endtask

    // Drive one M-stage instruction for one cycle and queue its W-stage image.
    task automatic op(input logic we, input logic rs, input logic rw, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                      input logic [31:0] expRd, input logic chkRd, input logic expMis);
        expT e;
        @(negedge clk);
        MemWriteM = we; ResultSrcM = rs; RegWriteM = rw; funct3M = f3;
        ALUResultM = addr; WriteDataM = wdata; RdM = rd; PCPlus4M = pcCnt;
        e.id = opId; e.rw = rw; e.rs = rs; e.alu = addr; e.rdData = expRd; e.chkRd = chkRd;
        e.rd = rd; e.pc = pcCnt; e.mis = expMis;
        q.push_back(e);
        opId++;
        pcCnt += 4;
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("RegWriteW",  e.id, {31'h0, RegWriteW},  {31'h0, e.rw});
                chk("ResultSrcW", e.id, {31'h0, ResultSrcW}, {31'h0, e.rs});
                chk("ALUResultW", e.id, ALUResultW,          e.alu);
                chk("RdW",        e.id, {27'h0, RdW},        {27'h0, e.rd});
                chk("PCPlus4W",   e.id, PCPlus4W,            e.pc);
                chk("MisalignW",  e.id, {31'h0, MisalignW},  {31'h0, e.mis});
                if (e.chkRd) chk("ReadDataW", e.id, ReadDataW, e.rdData);
            end
        end
    end

    initial begin : stim
        #1;
        chkResetOutputs(-1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        op(1, 0, 0, 3'b010, 32'h40,  32'h11111111, 5'd0, 32'h0, 0, 0);
        op(1, 0, 0, 3'b010, 32'h10,  32'hDEADBEEF, 5'd0, 32'h0, 0, 0);
        op(0, 1, 1, 3'b010, 32'h10,  32'h0,        5'd5, 32'hDEADBEEF, 1, 0);
        // Store and load to the same word in one cycle: the load sees the old contents.
        op(1, 1, 1, 3'b010, 32'h40,  32'h22222222, 5'd6, 32'h11111111, 1, 0);
        op(0, 1, 1, 3'b010, 32'h40,  32'h0,        5'd7, 32'h22222222, 1, 0);
        op(1, 0, 0, 3'b010, 32'h100, 32'hCAFEF00D, 5'd0, 32'h0, 0, 0);
        op(0, 1, 1, 3'b010, 32'h000, 32'h0,        5'd8, 32'hCAFEF00D, 1, 0);
`ifdef MEM_SUBWORD_EN
        op(0, 1, 1, 3'b010, 32'h13,  32'h0,        5'd9, 32'h00000000, 1, 1);
        op(0, 1, 1, 3'b000, 32'h10,  32'h0,        5'd9, 32'hFFFFFFEF, 1, 0);
        op(1, 0, 0, 3'b010, 32'h20,  32'h80FF7F01, 5'd0, 32'h0, 0, 0);
        op(0, 1, 1, 3'b000, 32'h23,  32'h0,        5'd1, 32'hFFFFFF80, 1, 0);
        op(0, 1, 1, 3'b100, 32'h23,  32'h0,        5'd2, 32'h00000080, 1, 0);
        op(0, 1, 1, 3'b001, 32'h22,  32'h0,        5'd3, 32'hFFFF80FF, 1, 0);
        op(0, 1, 1, 3'b101, 32'h22,  32'h0,        5'd4, 32'h000080FF, 1, 0);
        op(1, 0, 0, 3'b000, 32'h21,  32'h123456AB, 5'd0, 32'h0, 0, 0);
        op(0, 1, 1, 3'b010, 32'h20,  32'h0,        5'd5, 32'h80FFAB01, 1, 0);
        op(0, 1, 1, 3'b000, 32'h21,  32'h0,        5'd5, 32'hFFFFFFAB, 1, 0);
        op(1, 0, 0, 3'b001, 32'h21,  32'h0000BEEF, 5'd0, 32'h0, 0, 1);
        op(0, 1, 1, 3'b010, 32'h20,  32'h0,        5'd6, 32'h80FFAB01, 1, 0);
        op(1, 0, 0, 3'b001, 32'h22,  32'hFFFF1234, 5'd0, 32'h0, 0, 0);
        op(0, 1, 1, 3'b010, 32'h20,  32'h0,        5'd7, 32'h1234AB01, 1, 0);
        op(0, 1, 1, 3'b010, 32'h22,  32'h0,        5'd7, 32'h00000000, 1, 1);
`else
        op(0, 1, 1, 3'b010, 32'h13,  32'h0,        5'd9, 32'hDEADBEEF, 1, 0);
        op(0, 1, 1, 3'b000, 32'h10,  32'h0,        5'd9, 32'hDEADBEEF, 1, 0);
        op(1, 1, 0, 3'b001, 32'h21,  32'h0000BEEF, 5'd0, 32'h0, 0, 0);
        op(0, 1, 1, 3'b010, 32'h20,  32'h0,        5'd6, 32'h0000BEEF, 1, 0);
`endif
        // Bubble: read data is still captured though the WB mux ignores it.
        op(0, 0, 0, 3'b000, 32'h0,   32'h0,        5'd0, 32'hCAFEF00D, 1, 0);
        op(0, 1, 1, 3'b010, 32'h100, 32'h0,        5'd31, 32'hCAFEF00D, 1, 0);

        // Reset mid-run with a store pending to a known word.
        @(negedge clk);
        MemWriteM = 1'b1; ResultSrcM = 1'b0; RegWriteM = 1'b0; funct3M = 3'b010;
        ALUResultM = 32'h10; WriteDataM = 32'h55555555; RdM = 5'd3; PCPlus4M = 32'h400;
        #2 rst = 1'b0;
        #1 chkResetOutputs(-2);
        @(posedge clk);
        #1 chkResetOutputs(-3);
        @(negedge clk);
        rst = 1'b1;
        MemWriteM = 1'b0;
        op(0, 1, 1, 3'b010, 32'h10,  32'h0,        5'd4, 32'hDEADBEEF, 1, 0);
        op(0, 0, 0, 3'b000, 32'h0,   32'h0,        5'd0, 32'h0, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #3;
        chk("scoreboard drained", -4, q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
